// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle MIPS-subset main control unit.
//
// An eight-state FSM (FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP, TRAP) walks
// each instruction through its phases. The opcode is classified once, in
// DECODE, into a class register. Datapath controls are then decoded only from
// the state, class and branch-taken registers. This keeps them glitch-free and
// stable for the whole cycle.
//
// Optional feature (compile-time macro MEM_WAIT_EN):
//   defined   - MEM is held while mem_ready=0. The store's PC write is issued
//               only in the cycle mem_ready=1.
//   undefined - mem_ready is ignored and MEM lasts exactly one cycle.
//
// Ports
//   clk        in   system clock, all state on posedge
//   reset_n    in   asynchronous active-low reset
//   opcode     in   IR[31:26]
//   zero       in   ALU zero flag, sampled in EXEC
//   mem_ready  in   data-memory done (MEM_WAIT_EN only)
//   IRwrt      out  instruction register write enable
//   PCwrt      out  PC write enable (exactly once per instruction)
//   branch     out  select branch target (only together with PCwrt)
//   jump       out  select jump target (only together with PCwrt)
//   RegWrt     out  register file write enable
//   MemRd      out  data memory read
//   MemWrt     out  data memory write
//   ALUSrc     out  ALU B operand: 1 = immediate
//   MemtoReg   out  write-back source: 1 = memory data
//   RegDst     out  destination register: 1 = rd (R-type)
//   ExtOp      out  immediate extension: 1 = sign, 0 = zero
//   ALUOp      out  00 add, 01 sub, 10 funct, 11 or
//   state      out  current FSM state encoding
//   illegal    out  unlisted opcode trapped
// -----------------------------------------------------------------------------
module mc_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IRwrt,
    output logic       PCwrt,
    output logic       branch,
    output logic       jump,
    output logic       RegWrt,
    output logic       MemRd,
    output logic       MemWrt,
    output logic       ALUSrc,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       ExtOp,
    output logic [1:0] ALUOp,
    output logic [2:0] state,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_JUMP   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    // Class 0 is R-type, which is also the reset value of the class register.
    typedef enum logic [2:0] {
        C_R    = 3'd0,
        C_LW   = 3'd1,
        C_SW   = 3'd2,
        C_BEQ  = 3'd3,
        C_BNE  = 3'd4,
        C_J    = 3'd5,
        C_ADDI = 3'd6,
        C_ORI  = 3'd7
    } class_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    state_t r_state;
    class_t r_class;
    logic   r_taken;

    state_t w_next_state;
    class_t w_next_class;
    logic   w_next_taken;
    logic   w_mem_done;

`ifdef MEM_WAIT_EN
    assign w_mem_done = mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
    assign w_mem_done         = 1'b1;
`endif

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples the values from before this edge, regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
            r_class <= C_R;
            r_taken <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_class <= w_next_class;
            r_taken <= w_next_taken;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_class = r_class;
        w_next_taken = r_taken;
        unique case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                w_next_state = S_EXEC;
                case (opcode)
                    OP_R:    w_next_class = C_R;
                    OP_LW:   w_next_class = C_LW;
                    OP_SW:   w_next_class = C_SW;
                    OP_BEQ:  w_next_class = C_BEQ;
                    OP_BNE:  w_next_class = C_BNE;
                    OP_ADDI: w_next_class = C_ADDI;
                    OP_ORI:  w_next_class = C_ORI;
                    OP_J: begin
                        w_next_class = C_J;
                        w_next_state = S_JUMP;
                    end
                    default: w_next_state = S_TRAP;
                endcase
            end
            S_EXEC: begin
                // The branch outcome is captured now, so BRANCH is decoded from a
                // register rather than from a zero flag that may have moved on.
                case (r_class)
                    C_BEQ:   w_next_taken = zero;
                    C_BNE:   w_next_taken = ~zero;
                    default: w_next_taken = 1'b0;
                endcase
                case (r_class)
                    C_LW, C_SW:   w_next_state = S_MEM;
                    C_BEQ, C_BNE: w_next_state = S_BRANCH;
                    default:      w_next_state = S_WB;
                endcase
            end
            S_MEM: begin
                if (w_mem_done) begin
                    w_next_state = (r_class == C_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB, S_BRANCH, S_JUMP: w_next_state = S_FETCH;
            S_TRAP:                 w_next_state = S_TRAP;
            default:                w_next_state = S_FETCH;
        endcase
    end

    // Output decode uses registers only. The one exception is the store's PC
    // write under MEM_WAIT_EN. That write must coincide with the cycle in which
    // memory reports completion.
    always_comb begin
        IRwrt    = 1'b0;
        PCwrt    = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        RegWrt   = 1'b0;
        MemRd    = 1'b0;
        MemWrt   = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        ExtOp    = 1'b0;
        ALUOp    = 2'b00;
        illegal  = 1'b0;
        unique case (r_state)
            S_FETCH: IRwrt = 1'b1;
            S_EXEC: begin
                case (r_class)
                    C_R:          ALUOp = 2'b10;
                    C_BEQ, C_BNE: ALUOp = 2'b01;
                    C_ORI:        ALUOp = 2'b11;
                    default:      ALUOp = 2'b00;
                endcase
                ALUSrc = (r_class == C_LW) || (r_class == C_SW) ||
                         (r_class == C_ADDI) || (r_class == C_ORI);
                ExtOp  = (r_class != C_ORI);
            end
            S_MEM: begin
                if (r_class == C_LW) begin
                    MemRd = 1'b1;
                end else begin
                    MemWrt = 1'b1;
                    PCwrt  = w_mem_done;
                end
            end
            S_WB: begin
                RegWrt   = 1'b1;
                PCwrt    = 1'b1;
                MemtoReg = (r_class == C_LW);
                RegDst   = (r_class == C_R);
            end
            S_BRANCH: begin
                branch = r_taken;
                PCwrt  = 1'b1;
            end
            S_JUMP: begin
                jump  = 1'b1;
                PCwrt = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

    assign state = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl -- directed bench for mc_ctrl.
// A per-cycle vector table walks every instruction class. Hand-written
// sequences then cover latency, mid-instruction reset, the trap, and the
// memory-wait behaviour. Build with +define+MEM_WAIT_EN to exercise the
// wait variant.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       IRwrt, PCwrt, branch, jump, RegWrt, MemRd, MemWrt;
    logic       ALUSrc, MemtoReg, RegDst, ExtOp, illegal;
    logic [1:0] ALUOp;
    logic [2:0] state;

    int n_total = 0;
    int n_pass  = 0;

    // Output vector bit positions:
    // 13 IRwrt, 12 PCwrt, 11 branch, 10 jump, 9 RegWrt, 8 MemRd, 7 MemWrt,
    // 6 ALUSrc, 5 MemtoReg, 4 RegDst, 3 ExtOp, 2:1 ALUOp, 0 illegal.
    localparam logic [13:0] IR  = 14'h2000;
    localparam logic [13:0] PC  = 14'h1000;
    localparam logic [13:0] BR  = 14'h0800;
    localparam logic [13:0] JP  = 14'h0400;
    localparam logic [13:0] RW  = 14'h0200;
    localparam logic [13:0] MR  = 14'h0100;
    localparam logic [13:0] MW  = 14'h0080;
    localparam logic [13:0] AS  = 14'h0040;
    localparam logic [13:0] M2R = 14'h0020;
    localparam logic [13:0] RD  = 14'h0010;
    localparam logic [13:0] EX  = 14'h0008;
    localparam logic [13:0] SUB = 14'h0002;
    localparam logic [13:0] FN  = 14'h0004;
    localparam logic [13:0] ORO = 14'h0006;
    localparam logic [13:0] ILL = 14'h0001;

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic [2:0]  st;
        logic [13:0] out;
    } vec_t;

    vec_t vecs[$];

    mc_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .opcode   (opcode),
        .zero     (zero),
        .mem_ready(mem_ready),
        .IRwrt    (IRwrt),
        .PCwrt    (PCwrt),
        .branch   (branch),
        .jump     (jump),
        .RegWrt   (RegWrt),
        .MemRd    (MemRd),
        .MemWrt   (MemWrt),
        .ALUSrc   (ALUSrc),
        .MemtoReg (MemtoReg),
        .RegDst   (RegDst),
        .ExtOp    (ExtOp),
        .ALUOp    (ALUOp),
        .state    (state),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] obs();
        return {state, IRwrt, PCwrt, branch, jump, RegWrt, MemRd, MemWrt,
                ALUSrc, MemtoReg, RegDst, ExtOp, ALUOp, illegal};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic check_so(input string nm, input logic [2:0] st, input logic [13:0] o);
        check(nm, {15'b0, obs()}, {15'b0, st, o});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Short reset pulse inside the low clock phase; leaves the FSM in FETCH.
    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    function automatic void add(logic [5:0] op, logic z, logic [2:0] st, logic [13:0] o);
        vecs.push_back(vec_t'{op, z, st, o});
    endfunction

    // Counts posedges from FETCH back to FETCH; a runaway shows up as 20.
    task automatic run_latency(input string nm, input logic [5:0] op, input int exp_cycles);
        int n;
        n = 0;
        opcode = op;
        zero   = 1'b0;
        do begin
            step();
            n++;
        end while (state != 3'd0 && n < 20);
        check(nm, n, exp_cycles);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Opcode 0x3F in EXEC/WB/BRANCH rows shows that outputs ignore the live opcode.
        add(6'h00, 0, 0, IR); add(6'h00, 0, 1, 0); add(6'h3F, 0, 2, FN | EX);
        add(6'h3F, 0, 4, RW | PC | RD);
        add(6'h23, 0, 0, IR); add(6'h23, 0, 1, 0); add(6'h00, 0, 2, AS | EX);
        add(6'h00, 0, 3, MR); add(6'h00, 0, 4, RW | PC | M2R);
        add(6'h2B, 0, 0, IR); add(6'h2B, 0, 1, 0); add(6'h2B, 0, 2, AS | EX);
        add(6'h2B, 0, 3, MW | PC);
        // beq taken: zero flips in BRANCH, branch must still reflect the EXEC sample.
        add(6'h04, 0, 0, IR); add(6'h04, 0, 1, 0); add(6'h3F, 1, 2, SUB | EX);
        add(6'h3F, 0, 5, BR | PC);
        add(6'h04, 0, 0, IR); add(6'h04, 0, 1, 0); add(6'h04, 0, 2, SUB | EX);
        add(6'h04, 1, 5, PC);
        add(6'h05, 0, 0, IR); add(6'h05, 0, 1, 0); add(6'h05, 1, 2, SUB | EX);
        add(6'h05, 0, 5, PC);
        add(6'h05, 0, 0, IR); add(6'h05, 0, 1, 0); add(6'h05, 0, 2, SUB | EX);
        add(6'h05, 1, 5, BR | PC);
        add(6'h02, 0, 0, IR); add(6'h02, 0, 1, 0); add(6'h02, 0, 6, JP | PC);
        add(6'h08, 0, 0, IR); add(6'h08, 0, 1, 0); add(6'h08, 0, 2, AS | EX);
        add(6'h08, 0, 4, RW | PC);
        add(6'h0D, 0, 0, IR); add(6'h0D, 0, 1, 0); add(6'h0D, 0, 2, ORO | AS);
        add(6'h0D, 0, 4, RW | PC);

        reset_n   = 1'b0;
        opcode    = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #2;
        check_so("reset_state", 3'd0, IR);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            opcode = vecs[i].op;
            zero   = vecs[i].z;
            check_so($sformatf("vec%0d", i), vecs[i].st, vecs[i].out);
            step();
        end
        check_so("after_table_fetch", 3'd0, IR);

        run_latency("lat_j", 6'h02, 3);
        run_latency("lat_r", 6'h00, 4);
        run_latency("lat_lw", 6'h23, 5);

        // Reset in WB of an R-type: no write pulse while reset is low.
        opcode = 6'h00;
        step(); step(); step();
        check_so("r_in_wb", 3'd4, RW | PC | RD);
        #3;
        reset_n = 1'b0;
        #1;
        check_so("rst_in_wb_async", 3'd0, IR);
        step();
        check_so("rst_held_over_edge", 3'd0, IR);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("first_edge_leaves_fetch", {29'b0, state}, 32'd1);
        pulse_reset();

        // Reset in MEM of a store: abandoned with no PCwrt/MemWrt.
        opcode = 6'h2B;
        mem_ready = 1'b0;
        step(); step(); step();
        check("sw_reached_mem", {29'b0, state}, 32'd3);
        #3;
        reset_n = 1'b0;
        #1;
        check_so("rst_in_mem_async", 3'd0, IR);
        @(negedge clk);
        reset_n = 1'b1;
        mem_ready = 1'b1;

        // Unlisted opcode traps until reset.
        pulse_reset();
        opcode = 6'h3F;
        step(); step();
        for (int k = 0; k < 20; k++) begin
            opcode = 6'($urandom_range(0, 63));
            zero   = 1'($urandom_range(0, 1));
            check_so($sformatf("trap_hold%0d", k), 3'd7, ILL);
            step();
        end
        pulse_reset();
        check_so("trap_cleared_by_reset", 3'd0, IR);

        // Store with memory wait.
        opcode    = 6'h2B;
        zero      = 1'b0;
        mem_ready = 1'b0;
        step(); step(); step();
`ifdef MEM_WAIT_EN
        for (int k = 0; k < 3; k++) begin
            check_so($sformatf("sw_wait%0d", k), 3'd3, MW);
            step();
        end
        mem_ready = 1'b1;
        check_so("sw_ready", 3'd3, MW | PC);
        step();
        check_so("sw_wait_done", 3'd0, IR);
`else
        check_so("sw_nowait_mem", 3'd3, MW | PC);
        step();
        check_so("sw_nowait_done", 3'd0, IR);
`endif
        mem_ready = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
